// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared types for the RSA key-generation controller: FSM state encoding and
// the err_code values reported on the controller bus.
// No ports (package).
// -----------------------------------------------------------------------------
package rsa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CHECK    = 3'd1,
      ST_MULT     = 3'd2,
      ST_GCD_GO   = 3'd3,
      ST_GCD_WAIT = 3'd4,
      ST_FIX_D    = 3'd5,
      ST_DONE     = 3'd6,
      ST_FAIL     = 3'd7
   } keygen_state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_INPUT   = 2'd1;
   localparam logic [1:0] ERR_EXHAUST = 2'd2;

endpackage

// File: rtl/rsa_keygen_ctrl_if.sv
// -----------------------------------------------------------------------------
// rsa_keygen_ctrl_if
// Request/result bus of the RSA key-generation controller.
//   master : drives start, abort, p, q; observes results and status
//   slave  : the controller (consumes requests, drives results and status)
// Signals: start, abort, p[WIDTH], q[WIDTH], n/phi/e/d[2*WIDTH], busy, done,
//          err, err_code[2], and cycles[32] when RSA_KEYGEN_CYCLE_CNT_EN is
//          defined.
// -----------------------------------------------------------------------------
interface rsa_keygen_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 abort;
   logic [WIDTH-1:0]     p;
   logic [WIDTH-1:0]     q;
   logic [2*WIDTH-1:0]   n;
   logic [2*WIDTH-1:0]   phi;
   logic [2*WIDTH-1:0]   e;
   logic [2*WIDTH-1:0]   d;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [1:0]           err_code;
`ifdef RSA_KEYGEN_CYCLE_CNT_EN
   logic [31:0]          cycles;
`endif

   modport master (
      output start, abort, p, q,
      input  n, phi, e, d, busy, done, err, err_code
`ifdef RSA_KEYGEN_CYCLE_CNT_EN
      , input cycles
`endif
   );

   modport slave (
      input  start, abort, p, q,
      output n, phi, e, d, busy, done, err, err_code
`ifdef RSA_KEYGEN_CYCLE_CNT_EN
      , output cycles
`endif
   );
endinterface

// File: rtl/Mult.sv
// -----------------------------------------------------------------------------
// Mult
// Shift-and-add sequential multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (async active-low), start (1-cycle pulse, restarts any run
//        in progress), a[W], b[W] sampled on start, product[2W] held until the
//        next start, finish (1-cycle pulse when product is valid).
// -----------------------------------------------------------------------------
module Mult #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] product,
   output logic           finish
);
   localparam int CW = $clog2(W + 1);

   logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           run_q, run_d, finish_q, finish_d;

   // Next-state: load on start, then one add/shift step per cycle for W cycles.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      finish_d = 1'b0;
      if (start) begin
         acc_d    = {(2*W){1'b0}};
         mcand_d  = {{W{1'b0}}, a};
         mplier_d = b;
         cnt_d    = {CW{1'b0}};
         run_d    = 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end else begin
            acc_d = acc_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (cnt_q == CW'(W - 1)) begin
            run_d    = 1'b0;
            finish_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         run_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= {(2*W){1'b0}};
         mcand_q  <= {(2*W){1'b0}};
         mplier_q <= {W{1'b0}};
         cnt_q    <= {CW{1'b0}};
         run_q    <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         finish_q <= finish_d;
      end
   end

   assign product = acc_q;
   assign finish  = finish_q;
endmodule

// File: rtl/gcd.sv
// -----------------------------------------------------------------------------
// gcd
// Sequential extended Euclid, one quotient step per cycle.
// Ports: clk, rst_n (async active-low), start (1-cycle pulse, restarts),
//        a[W], b[W] sampled on start, g[W] = gcd(a,b), t[W] two's-complement
//        coefficient with a*s + b*t = g, finish (1-cycle pulse).
// Only the Bezout coefficient of b is tracked. Coefficient arithmetic is done
// modulo 2^W: the final coefficient satisfies |t| <= a/2, so it comes out
// exact even if earlier intermediates wrapped.
// -----------------------------------------------------------------------------
module gcd #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] g,
   output logic [W-1:0] t,
   output logic         finish
);
   logic [W-1:0] old_r_q, old_r_d, r_q, r_d;
   logic [W-1:0] old_t_q, old_t_d, t_q, t_d;
   logic         run_q, run_d, finish_q, finish_d;
   logic [W-1:0] quo_s, rem_s, quo_t_s;

   // Next-state: one remainder/coefficient update per cycle until r reaches 0.
   always_comb begin
      old_r_d  = old_r_q;
      r_d      = r_q;
      old_t_d  = old_t_q;
      t_d      = t_q;
      run_d    = run_q;
      finish_d = 1'b0;
      quo_s    = {W{1'b0}};
      rem_s    = {W{1'b0}};
      quo_t_s  = {W{1'b0}};
      if (start) begin
         old_r_d = a;
         r_d     = b;
         old_t_d = {W{1'b0}};
         t_d     = W'(1);
         run_d   = 1'b1;
      end else if (run_q) begin
         if (r_q == {W{1'b0}}) begin
            run_d    = 1'b0;
            finish_d = 1'b1;
         end else begin
            quo_s   = old_r_q / r_q;
            rem_s   = old_r_q % r_q;
            quo_t_s = quo_s * t_q;
            old_r_d = r_q;
            r_d     = rem_s;
            old_t_d = t_q;
            t_d     = old_t_q - quo_t_s;
         end
      end else begin
         run_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         old_r_q  <= {W{1'b0}};
         r_q      <= {W{1'b0}};
         old_t_q  <= {W{1'b0}};
         t_q      <= {W{1'b0}};
         run_q    <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         old_r_q  <= old_r_d;
         r_q      <= r_d;
         old_t_q  <= old_t_d;
         t_q      <= t_d;
         run_q    <= run_d;
         finish_q <= finish_d;
      end
   end

   assign g      = old_r_q;
   assign t      = old_t_q;
   assign finish = finish_q;
endmodule

// File: rtl/rsa_keygen_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_keygen_ctrl
// RSA key-generation controller: n = p*q, phi = (p-1)*(q-1), then searches odd
// e upward from E_START for gcd(phi, e) == 1 and outputs d = e^-1 mod phi.
// Ports: clk, rst_n (async active-low), bus (rsa_keygen_ctrl_if.slave):
//        start/abort/p/q in; n/phi/e/d/busy/done/err/err_code out.
// Optional: RSA_KEYGEN_CYCLE_CNT_EN adds bus.cycles, a saturating count of
//           busy cycles, cleared on each accepted start.
// Sub-units: two Mult instances (n and phi in parallel) and one gcd.
// -----------------------------------------------------------------------------
module rsa_keygen_ctrl
   import rsa_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int E_START   = 3,
   parameter  int MAX_TRIES = 64,
   localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   rsa_keygen_ctrl_if.slave bus
);
   localparam int                W2      = 2 * WIDTH;
   localparam logic [W2-1:0]     E_INIT  = W2'(E_START);
   localparam logic [TRY_W-1:0]  TRY_MAX = TRY_W'(MAX_TRIES);

   keygen_state_t    state_q, state_d;
   logic [WIDTH-1:0] p_q, p_d, q_q, q_d;
   logic [W2-1:0]    n_q, n_d, phi_q, phi_d, e_q, e_d, d_q, d_d, t_q, t_d;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             n_seen_q, n_seen_d, phi_seen_q, phi_seen_d;
   logic             mult_start_q, mult_start_d, gcd_start_q, gcd_start_d;

   logic [WIDTH-1:0] p_m1_s, q_m1_s;
   logic [W2-1:0]    prod_n_s, prod_phi_s, gcd_g_s, gcd_t_s;
   logic             fin_n_s, fin_phi_s, gcd_fin_s;
   logic             n_seen_s, phi_seen_s, start_ok_s, input_bad_s;

   assign p_m1_s = p_q - WIDTH'(1);
   assign q_m1_s = q_q - WIDTH'(1);

   Mult #(.W(WIDTH)) u_mult_n (
      .clk(clk), .rst_n(rst_n), .start(mult_start_q),
      .a(p_q), .b(q_q), .product(prod_n_s), .finish(fin_n_s)
   );

   Mult #(.W(WIDTH)) u_mult_phi (
      .clk(clk), .rst_n(rst_n), .start(mult_start_q),
      .a(p_m1_s), .b(q_m1_s), .product(prod_phi_s), .finish(fin_phi_s)
   );

   gcd #(.W(W2)) u_gcd (
      .clk(clk), .rst_n(rst_n), .start(gcd_start_q),
      .a(phi_q), .b(e_q), .g(gcd_g_s), .t(gcd_t_s), .finish(gcd_fin_s)
   );

   // FSM next-state and output computation.
   // A finish pulse seen while our own start pulse is still high belongs to a
   // run that was aborted and is being restarted, so it is ignored.
   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      q_d          = q_q;
      n_d          = n_q;
      phi_d        = phi_q;
      e_d          = e_q;
      d_d          = d_q;
      t_d          = t_q;
      tries_d      = tries_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      err_code_d   = err_code_q;
      n_seen_d     = n_seen_q;
      phi_seen_d   = phi_seen_q;
      mult_start_d = 1'b0;
      gcd_start_d  = 1'b0;
      start_ok_s   = bus.start && !bus.abort &&
                     (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);
      input_bad_s  = (p_q < WIDTH'(3)) || (q_q < WIDTH'(3)) || (p_q == q_q);
      n_seen_s     = n_seen_q || (fin_n_s && !mult_start_q);
      phi_seen_s   = phi_seen_q || (fin_phi_s && !mult_start_q);

      if (bus.abort && busy_q) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (start_ok_s) begin
                  p_d        = bus.p;
                  q_d        = bus.q;
                  err_code_d = ERR_NONE;
                  d_d        = {W2{1'b0}};
                  n_d        = {W2{1'b0}};
                  phi_d      = {W2{1'b0}};
                  e_d        = E_INIT;
                  tries_d    = {TRY_W{1'b0}};
                  busy_d     = 1'b1;
                  state_d    = ST_CHECK;
               end else begin
                  state_d = state_q;
               end
            end
            ST_CHECK: begin
               if (input_bad_s) begin
                  err_code_d = ERR_INPUT;
                  err_d      = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ST_FAIL;
               end else begin
                  mult_start_d = 1'b1;
                  n_seen_d     = 1'b0;
                  phi_seen_d   = 1'b0;
                  state_d      = ST_MULT;
               end
            end
            ST_MULT: begin
               if (n_seen_s && phi_seen_s) begin
                  n_d     = prod_n_s;
                  phi_d   = prod_phi_s;
                  state_d = ST_GCD_GO;
               end else begin
                  n_seen_d   = n_seen_s;
                  phi_seen_d = phi_seen_s;
               end
            end
            ST_GCD_GO: begin
               // Bound check comes first so a wrapped e is never handed to gcd.
               if ((e_q >= phi_q) || (tries_q == TRY_MAX)) begin
                  err_code_d = ERR_EXHAUST;
                  err_d      = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ST_FAIL;
               end else begin
                  gcd_start_d = 1'b1;
                  tries_d     = tries_q + TRY_W'(1);
                  state_d     = ST_GCD_WAIT;
               end
            end
            ST_GCD_WAIT: begin
               if (gcd_fin_s && !gcd_start_q) begin
                  if (gcd_g_s == W2'(1)) begin
                     t_d     = gcd_t_s;
                     state_d = ST_FIX_D;
                  end else begin
                     e_d     = e_q + W2'(2);
                     state_d = ST_GCD_GO;
                  end
               end else begin
                  state_d = ST_GCD_WAIT;
               end
            end
            ST_FIX_D: begin
               // Map a negative Bezout coefficient into 0..phi-1.
               if (t_q[W2-1]) begin
                  d_d = t_q + phi_q;
               end else begin
                  d_d = t_q;
               end
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
            default: begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         p_q          <= {WIDTH{1'b0}};
         q_q          <= {WIDTH{1'b0}};
         n_q          <= {W2{1'b0}};
         phi_q        <= {W2{1'b0}};
         e_q          <= E_INIT;
         d_q          <= {W2{1'b0}};
         t_q          <= {W2{1'b0}};
         tries_q      <= {TRY_W{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
         n_seen_q     <= 1'b0;
         phi_seen_q   <= 1'b0;
         mult_start_q <= 1'b0;
         gcd_start_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         q_q          <= q_d;
         n_q          <= n_d;
         phi_q        <= phi_d;
         e_q          <= e_d;
         d_q          <= d_d;
         t_q          <= t_d;
         tries_q      <= tries_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         n_seen_q     <= n_seen_d;
         phi_seen_q   <= phi_seen_d;
         mult_start_q <= mult_start_d;
         gcd_start_q  <= gcd_start_d;
      end
   end

   assign bus.n        = n_q;
   assign bus.phi      = phi_q;
   assign bus.e        = e_q;
   assign bus.d        = d_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;

`ifdef RSA_KEYGEN_CYCLE_CNT_EN
   logic [31:0] cycles_q, cycles_d;

   // Busy-cycle counter: clears on accepted start, saturates at all-ones.
   always_comb begin
      if (start_ok_s && !busy_q) begin
         cycles_d = 32'd0;
      end else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) begin
         cycles_d = cycles_q + 32'd1;
      end else begin
         cycles_d = cycles_q;
      end
   end

   // Busy-cycle counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles_q <= 32'd0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign bus.cycles = cycles_q;
`endif
endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
module tb_rsa_keygen_ctrl;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rsa_keygen_ctrl_if #(.WIDTH(WIDTH)) bus_a ();
   rsa_keygen_ctrl_if #(.WIDTH(WIDTH)) bus_b ();

   rsa_keygen_ctrl #(.WIDTH(WIDTH), .E_START(3), .MAX_TRIES(64)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
   );
   rsa_keygen_ctrl #(.WIDTH(WIDTH), .E_START(3), .MAX_TRIES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Event counters observed at each rising edge.
   int gcd_starts_a = 0, mult_starts_a = 0, done_a = 0, err_a = 0, busy_cyc_a = 0;
   int done_b = 0, err_b = 0;
   always @(posedge clk) begin
      if (dut.u_gcd.start)    gcd_starts_a  = gcd_starts_a + 1;
      if (dut.u_mult_n.start) mult_starts_a = mult_starts_a + 1;
      if (bus_a.done)         done_a        = done_a + 1;
      if (bus_a.err)          err_a         = err_a + 1;
      if (bus_a.busy)         busy_cyc_a    = busy_cyc_a + 1;
      if (bus_b.done)         done_b        = done_b + 1;
      if (bus_b.err)          err_b         = err_b + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
      int unsigned x = a;
      int unsigned y = b;
      int unsigned r;
      while (y != 0) begin
         r = x % y;
         x = y;
         y = r;
      end
      return x;
   endfunction

   function automatic int unsigned inv_ref(input int unsigned ev, input int unsigned m);
      for (int unsigned k = 1; k < m; k++) begin
         if ((longint'(ev) * longint'(k)) % longint'(m) == 64'sd1) return k;
      end
      return 0;
   endfunction

   task automatic model(input int unsigned p, input int unsigned q, input int unsigned mt,
                        output int unsigned en, output int unsigned ephi,
                        output int unsigned ee, output int unsigned ed,
                        output int unsigned ecode, output int unsigned etries);
      bit fin = 1'b0;
      en = 0; ephi = 0; ee = 3; ed = 0; etries = 0; ecode = 0;
      if (p < 3 || q < 3 || p == q) begin
         ecode = 1;
      end else begin
         en   = p * q;
         ephi = (p - 1) * (q - 1);
         while (!fin) begin
            if (ee >= ephi || etries == mt) begin
               ecode = 2;
               fin   = 1'b1;
            end else begin
               etries = etries + 1;
               if (gcd_ref(ephi, ee) == 1) begin
                  ed  = inv_ref(ee, ephi);
                  fin = 1'b1;
               end else begin
                  ee = ee + 2;
               end
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic start_a(input int unsigned p, input int unsigned q);
      @(negedge clk);
      bus_a.p     = WIDTH'(p);
      bus_a.q     = WIDTH'(q);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
   endtask

   task automatic wait_end_a(output bit gd, output bit ge, output int lat);
      gd = 1'b0; ge = 1'b0; lat = 0;
      for (int i = 1; i <= 4000; i++) begin
         @(negedge clk);
         if (bus_a.done || bus_a.err) begin
            gd  = bus_a.done;
            ge  = bus_a.err;
            lat = i;
            break;
         end
      end
      if (!gd && !ge) check("timeout_a", 32'd0, 32'd1);
   endtask

   task automatic run_a(input int unsigned p, input int unsigned q, input bit chk_lat);
      int unsigned en, ephi, ee, ed, ecode, etries;
      int g0, m0, b0, d0, e0, lat;
      bit gd, ge;
      model(p, q, 64, en, ephi, ee, ed, ecode, etries);
      g0 = gcd_starts_a; m0 = mult_starts_a; b0 = busy_cyc_a; d0 = done_a; e0 = err_a;
      start_a(p, q);
      wait_end_a(gd, ge, lat);
      check("done_flag", 32'(gd), 32'(ecode == 0));
      check("err_flag", 32'(ge), 32'(ecode != 0));
      check("err_code", 32'(bus_a.err_code), ecode);
      check("n", 32'(bus_a.n), en);
      check("phi", 32'(bus_a.phi), ephi);
      check("e", 32'(bus_a.e), ee);
      check("d", 32'(bus_a.d), ed);
      check("busy_end", 32'(bus_a.busy), 32'd0);
      check("gcd_starts", 32'(gcd_starts_a - g0), etries);
      check("mult_starts", 32'(mult_starts_a - m0), 32'(ecode != 1));
`ifdef RSA_KEYGEN_CYCLE_CNT_EN
      check("cycles", bus_a.cycles, 32'(busy_cyc_a - b0));
`endif
      if (chk_lat) check("err_latency", 32'(lat), 32'd1);
      @(negedge clk);
      check("pulse_len", 32'({bus_a.done, bus_a.err}), 32'd0);
      check("one_pulse", 32'((done_a - d0) + (err_a - e0)), 32'd1);
      check("n_hold", 32'(bus_a.n), en);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int unsigned plist [16] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 251};
      int unsigned en, ephi, ee, ed, ecode, etries;
      int g0, d0, e0, db0;
      bit seen;

      rst_n = 1'b0;
      bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.p = '0; bus_a.q = '0;
      bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.p = '0; bus_b.q = '0;
      repeat (3) @(negedge clk);
      check("rst_n", 32'(bus_a.n), 32'd0);
      check("rst_phi", 32'(bus_a.phi), 32'd0);
      check("rst_e", 32'(bus_a.e), 32'd3);
      check("rst_d", 32'(bus_a.d), 32'd0);
      check("rst_status", 32'({bus_a.busy, bus_a.done, bus_a.err}), 32'd0);
      check("rst_err_code", 32'(bus_a.err_code), 32'd0);
      check("rst_e_b", 32'(bus_b.e), 32'd3);
`ifdef RSA_KEYGEN_CYCLE_CNT_EN
      check("rst_cycles", bus_a.cycles, 32'd0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed: classic example, then restart and hold behaviour.
      run_a(11, 13, 1'b0);
      check("tp1_e", 32'(bus_a.e), 32'd7);
      check("tp1_d", 32'(bus_a.d), 32'd103);
      run_a(5, 7, 1'b0);
      repeat (5) @(negedge clk);
      check("hold_n", 32'(bus_a.n), 32'd35);
      check("hold_d", 32'(bus_a.d), 32'd5);
      run_a(3, 5, 1'b0);
      check("tp2_d", 32'(bus_a.d), 32'd3);

      // Invalid inputs: err two cycles after start, no multiplier start.
      run_a(7, 7, 1'b1);
      run_a(2, 11, 1'b1);

      // Search exhaustion with MAX_TRIES = 1.
      model(11, 13, 1, en, ephi, ee, ed, ecode, etries);
      db0 = done_b;
      @(negedge clk);
      bus_b.p = 8'd11; bus_b.q = 8'd13; bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bus_b.err || bus_b.done) begin
            seen = 1'b1;
            break;
         end
      end
      check("b_ended", 32'(seen), 32'd1);
      check("b_err", 32'(bus_b.err), 32'd1);
      check("b_err_code", 32'(bus_b.err_code), ecode);
      check("b_e", 32'(bus_b.e), ee);
      check("b_e_const", 32'(bus_b.e), 32'd5);
      check("b_n", 32'(bus_b.n), en);
      repeat (5) @(negedge clk);
      check("b_no_done", 32'(done_b - db0), 32'd0);

      // Abort in GCD_WAIT, with an ignored mid-run start first.
      g0 = gcd_starts_a; d0 = done_a; e0 = err_a;
      start_a(11, 13);
      @(negedge clk);
      bus_a.p = 8'd5; bus_a.q = 8'd7; bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (gcd_starts_a != g0) begin
            seen = 1'b1;
            break;
         end
      end
      check("ab_reach_gcd", 32'(seen), 32'd1);
      check("ab_busy_before", 32'(bus_a.busy), 32'd1);
      check("ab_n_ignored_start", 32'(bus_a.n), 32'd143);
      check("ab_tries", 32'(dut.tries_q), 32'd1);
      bus_a.abort = 1'b1;
      @(negedge clk);
      bus_a.abort = 1'b0;
      check("ab_busy_after", 32'(bus_a.busy), 32'd0);
      repeat (40) @(negedge clk);
      check("ab_still_idle", 32'(bus_a.busy), 32'd0);
      check("ab_no_pulse", 32'((done_a - d0) + (err_a - e0)), 32'd0);
      check("ab_partial_phi", 32'(bus_a.phi), 32'd120);
      check("ab_partial_e", 32'(bus_a.e), 32'd3);
      run_a(11, 13, 1'b0);
      check("ab_rerun_d", 32'(bus_a.d), 32'd103);

      // Randomized pairs against the model.
      for (int k = 0; k < 10; k++) begin
         run_a(plist[$urandom_range(0, 15)], plist[$urandom_range(0, 15)], 1'b0);
      end

      // Asynchronous reset in the middle of MULT.
      d0 = done_a;
      start_a(11, 13);
      @(negedge clk);
      check("mr_busy_pre", 32'(bus_a.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_busy", 32'(bus_a.busy), 32'd0);
      check("mr_e", 32'(bus_a.e), 32'd3);
      check("mr_n", 32'(bus_a.n), 32'd0);
      check("mr_err_code", 32'(bus_a.err_code), 32'd0);
`ifdef RSA_KEYGEN_CYCLE_CNT_EN
      check("mr_cycles", bus_a.cycles, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("mr_no_done", 32'(done_a - d0), 32'd0);
      check("mr_idle", 32'(bus_a.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rsa_keygen_ctrl.md
Name: rsa_keygen_ctrl

Overview:
Parametrised RSA key-generation controller that computes n = p*q and phi = (p-1)*(q-1).
It then searches odd e upward from E_START for gcd(e, phi) = 1 and outputs d = e^-1 mod phi.
It succeeds the fixed-run key generator: explicit start/busy/done/err handshake, input validation, bounded search with failure reporting, abort, and results held until the next start.
It sits in front of the modexp datapath and reuses the team's sequential multiplier (Mult) and extended-Euclid (gcd) blocks. Both have one-cycle start and finish pulse handshakes.

Parameters:
WIDTH, 8, width of primes p and q; n, phi, e and d are 2*WIDTH.
E_START, 3, first candidate e; must be odd and >= 3.
MAX_TRIES, 64, maximum number of e candidates tested before failure.
TRY_W, $clog2(MAX_TRIES+1), width of the try counter (derived, do not override).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE, DONE or FAIL
abort  in  1  synchronous cancel; returns to IDLE next cycle
p  in  WIDTH  prime 1; captured on accepted start
q  in  WIDTH  prime 2; captured on accepted start
n  out  2*WIDTH  modulus p*q
phi  out  2*WIDTH  totient
e  out  2*WIDTH  public exponent
d  out  2*WIDTH  private exponent, range 0..phi-1
busy  out  1  high from the cycle after accepted start until DONE, FAIL or IDLE
done  out  1  one-cycle pulse on success
err  out  1  one-cycle pulse on failure
err_code  out  2  0 none, 1 invalid input, 2 search exhausted; held until next start

Behaviour:
- Reset: all outputs 0, except e = E_START. State IDLE, try counter 0.
- States: IDLE, CHECK, MULT, GCD_GO, GCD_WAIT, FIX_D, DONE, FAIL.
- Accepted start (state IDLE, DONE or FAIL):
  - latch p and q;
  - clear err_code, d, n and phi;
  - set e = E_START and tries = 0;
  - go to CHECK.
- start while busy is ignored, with no effect on outputs.
- CHECK (1 cycle):
  - if p < 3, q < 3, or p == q: go to FAIL with err_code = 1;
  - otherwise go to MULT and pulse start to both multipliers in the same cycle.
- MULT: wait until both multiplier finishes have been seen; they may arrive in different cycles, so hold a sticky flag per unit. Register n and phi, then go to GCD_GO.
- GCD_GO (1 cycle):
  - if e >= phi or tries == MAX_TRIES: go to FAIL with err_code = 2;
  - otherwise pulse gcd start with a = phi and b = e, increment tries, and go to GCD_WAIT.
- GCD_WAIT, on gcd finish:
  - gcd == 1: go to FIX_D and capture t;
  - otherwise e = e + 2 and go to GCD_GO.
- FIX_D (1 cycle): d = t + phi if t is negative (signed, 2*WIDTH), else d = t. Then go to DONE.
- DONE and FAIL:
  - on entry, pulse done or err for exactly 1 cycle and drop busy the same cycle;
  - stay there, holding all outputs, until the next start.
- abort is honoured in any busy state: go to IDLE next cycle, busy = 0, no done/err pulse. Outputs keep their partial values. Sub-unit finish pulses arriving after the abort are ignored by IDLE.
- abort and start in the same cycle: abort wins.
- Arithmetic widths:
  - e + 2 wraps modulo 2^(2*WIDTH), but the e >= phi check precedes any test, so a wrapped value is never tested;
  - tries saturates at MAX_TRIES.
- Latency is variable (dominated by the sub-units). Ordering is fixed: n and phi are valid before the first gcd start, and d is valid in the done cycle.

Optional Feature:
Macro RSA_KEYGEN_CYCLE_CNT_EN.
- Defined: adds output cycles (32 bits). It clears on accepted start, increments every busy cycle, saturates at 2^32-1, and holds after DONE, FAIL or abort. Reset value 0.
- Not defined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package rsa_pkg: state enum for keygen_state_t; err_code localparams ERR_NONE, ERR_INPUT and ERR_EXHAUST.
- No new sub-module. Reuse Mult (instantiated twice) and gcd. The FSM, try counter and d fix-up stay in rsa_keygen_ctrl.

Test Plan:
- WIDTH = 8, p = 11, q = 13 -> n = 143, phi = 120. e = 3 and e = 5 are rejected; e = 7 with d = 103. One done pulse, err_code = 0, 3 gcd starts observed.
- p = 5, q = 7 -> n = 35, phi = 24, e = 5, d = 5. Then start again with p = 3, q = 5 -> n = 15, phi = 8, e = 3, d = 3. The previous outputs hold until that restart.
- p = 7, q = 7 -> err pulse 2 cycles after start, err_code = 1, no multiplier start. p = 2, q = 11 -> same response.
- MAX_TRIES = 1, p = 11, q = 13 -> e = 3 is rejected, then err with err_code = 2 and e = 5; done never pulses.
- Abort: abort while in GCD_WAIT for p = 11, q = 13 -> IDLE next cycle, busy = 0, no done/err pulse. A start pulsed mid-run is ignored (the tries count is unchanged). A fresh start afterwards completes with e = 7, d = 103.
- Async reset asserted mid-MULT -> all outputs go to their reset values immediately, e = E_START. With RSA_KEYGEN_CYCLE_CNT_EN defined, cycles = 0.
